// File: rtl/op_display_scheduler.sv
// op_display_scheduler: latches an operand, captures the selected operation image after settling,
// and scans the held image onto a multiplexed six-digit seven-segment bus.
module op_display_scheduler #(
  parameter int NUM_OPS = 8,
  parameter int SETTLE = 2,
  parameter int DWELL = 50000
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic [2:0]             op_sel,
  input  logic [5:0]             bits_in,
  input  logic [NUM_OPS*42-1:0]  op_display,
  output logic [5:0]             op_bits,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [41:0]            disp,
  output logic [6:0]             seg,
  output logic [5:0]             digit_en
);
  localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  localparam int DW = DWELL > 1 ? $clog2(DWELL) : 1;
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE} state_t;
  state_t state, state_nx;
  logic [SW-1:0] cnt;
  logic [DW-1:0] dwell;
  logic [2:0] sel_q, d;
  logic [41:0] imgs [8];
  logic [6:0] digs [8];
  logic sel_ok;
  // Unattached slots and digits read as zero so selects never reach outside the buses
  for (genvar k = 0; k < 8; k++) begin : g_tab
    if (k < NUM_OPS) begin : g_img
      assign imgs[k] = op_display[42*k +: 42];
    end else begin : g_nimg
      assign imgs[k] = '0;
    end
    if (k < 6) begin : g_dig
      assign digs[k] = disp[7*k +: 7];
    end else begin : g_ndig
      assign digs[k] = '0;
    end
  end
  assign sel_ok = 32'(sel_q) < NUM_OPS;
  always_comb begin
    state_nx = state == S_IDLE   ? (start ? S_SETTLE : S_IDLE) :
               state == S_SETTLE ? (cnt == '0 ? S_CAPTURE : S_SETTLE) : S_IDLE;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      disp    <= '0;
      op_bits <= '0;
      sel_q   <= '0;
      cnt     <= '0;
    end else begin
      state <= state_nx;
      busy  <= state_nx != S_IDLE;
      done  <= state == S_CAPTURE;
      if (state == S_IDLE && start) begin
        op_bits <= bits_in;
        sel_q   <= op_sel;
        cnt     <= SW'(SETTLE - 1);
      end else if (state == S_SETTLE) begin
        cnt <= cnt - 1'b1;
      end
      if (state == S_CAPTURE) begin
        disp <= sel_ok ? imgs[sel_q] : '0;
        err  <= !sel_ok;
      end
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dwell <= '0;
      d     <= '0;
    end else if (dwell == DW'(DWELL - 1)) begin
      dwell <= '0;
      d     <= d == 3'd5 ? 3'd0 : d + 3'd1;
    end else begin
      dwell <= dwell + 1'b1;
    end
  end
  assign digit_en = 6'b1 << d;
  assign seg      = digs[d];
endmodule

// File: tb/tb_op_display_scheduler.sv
// tb_op_display_scheduler: two configurations driven by shared stimulus and checked every cycle
// against a request/timeline reference model.
module tb_op_display_scheduler;
  localparam int NO [2] = '{8, 4};
  localparam int ST [2] = '{2, 3};
  localparam int DW [2] = '{4, 1};
  logic clk = 1'b0, resetn = 1'b0, start = 1'b0;
  logic [2:0] op_sel = '0;
  logic [5:0] bits_in = '0;
  logic [41:0] img [8];
  logic [335:0] img_bus;
  logic [5:0] op_bits [2];
  logic busy [2], done [2], err [2];
  logic [41:0] disp [2];
  logic [6:0] seg [2];
  logic [5:0] digit_en [2];
  int left [2], cyc [2];
  logic [2:0] m_sel [2];
  logic [5:0] m_bits [2];
  logic [41:0] m_disp [2];
  logic m_err [2], m_done [2];
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;
  for (genvar g = 0; g < 8; g++) begin : g_bus
    assign img_bus[42*g +: 42] = img[g];
  end

  op_display_scheduler #(.NUM_OPS(8), .SETTLE(2), .DWELL(4)) u0 (
    .clk(clk), .resetn(resetn), .start(start), .op_sel(op_sel), .bits_in(bits_in),
    .op_display(img_bus), .op_bits(op_bits[0]), .busy(busy[0]), .done(done[0]),
    .err(err[0]), .disp(disp[0]), .seg(seg[0]), .digit_en(digit_en[0]));
  op_display_scheduler #(.NUM_OPS(4), .SETTLE(3), .DWELL(1)) u1 (
    .clk(clk), .resetn(resetn), .start(start), .op_sel(op_sel), .bits_in(bits_in),
    .op_display(img_bus[167:0]), .op_bits(op_bits[1]), .busy(busy[1]), .done(done[1]),
    .err(err[1]), .disp(disp[1]), .seg(seg[1]), .digit_en(digit_en[1]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      left[i] = 0; cyc[i] = 0; m_sel[i] = '0; m_bits[i] = '0;
      m_disp[i] = '0; m_err[i] = 1'b0; m_done[i] = 1'b0;
    end
  endtask

  // A request keeps the block busy for SETTLE+1 cycles; the image is taken on the last of those edges
  task automatic model_edge();
    if (!resetn) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      cyc[i]++;
      m_done[i] = 1'b0;
      if (left[i] > 0) begin
        left[i]--;
        if (left[i] == 0) begin
          m_err[i]  = int'(m_sel[i]) >= NO[i];
          m_disp[i] = m_err[i] ? 42'b0 : img[m_sel[i]];
          m_done[i] = 1'b1;
        end
      end else if (start) begin
        left[i]   = ST[i] + 1;
        m_sel[i]  = op_sel;
        m_bits[i] = bits_in;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      int dd;
      logic [41:0] sh;
      dd = (cyc[i] / DW[i]) % 6;
      sh = m_disp[i] >> (7 * dd);
      check($sformatf("u%0d.op_bits", i), op_bits[i], m_bits[i]);
      check($sformatf("u%0d.busy", i), busy[i], left[i] > 0);
      check($sformatf("u%0d.done", i), done[i], m_done[i]);
      check($sformatf("u%0d.err", i), err[i], m_err[i]);
      check($sformatf("u%0d.disp", i), disp[i], m_disp[i]);
      check($sformatf("u%0d.digit_en", i), digit_en[i], 6'b1 << dd);
      check($sformatf("u%0d.seg", i), seg[i], sh[6:0]);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #2;
    check_all();
  endtask

  task automatic request(input logic [2:0] s, input logic [5:0] b);
    op_sel = s; bits_in = b; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 8; k++) img[k] = 42'({$urandom, $urandom});
    img[3] = {7'h3F, 7'h4F, 7'h40, 7'h3F, 7'h4F, 7'h40};
    model_reset();
    #3 check_all();
    #9 resetn = 1'b1;
    tick();
    request(3'd3, 6'b101100);
    repeat (5) tick();
    request(3'd3, 6'd7);
    op_sel = 3'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    request(3'd1, 6'd9);
    repeat (6) tick();
    request(3'd6, 6'd21);
    repeat (5) tick();
    request(3'd0, 6'd42);
    repeat (5) tick();
    img[3] = 42'({$urandom, $urandom});
    for (int t = 0; t < 30 && cyc[0] % 24 != 6; t++) tick();
    check("scan_align", 64'(cyc[0] % 24), 64'd6);
    request(3'd3, 6'd5);
    repeat (6) tick();
    request(3'd2, 6'd33);
    tick();
    #1 resetn = 1'b0;
    #1 model_reset();
    check_all();
    tick();
    tick();
    #1 resetn = 1'b1;
    repeat (8) tick();
    for (int n = 0; n < 600; n++) begin
      start   = $urandom_range(0, 3) == 0;
      op_sel  = 3'($urandom);
      bits_in = 6'($urandom);
      if ($urandom_range(0, 7) == 0) img[$urandom_range(0, 7)] = 42'({$urandom, $urandom});
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
